coe_wr_pack: RTL and testbench
==============================

# coe_wr_pack

Coefficient-buffer write packer for the CABAC coefficient memory. It accepts one quantized 4x4 block per handshake from the rec/quant side and pairs vertically adjacent blocks (same 4x4 x, 4x4 y differing only in bit 0) into one 32-coefficient memory word. The word layout is exactly the one the CABAC read path de-interleaves, so read-back reproduces the input block bit for bit. Unpaired halves are drained on a mismatch or on an explicit flush at CU end.

## Interface

Parameters:
- none; coefficient width is `` `COEFF_WIDTH `` (enc_defines.v).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- blk_val_i  in  1  input block valid.
- blk_rdy_o  out  1  input block ready.
- blk_sel_i  in  2  plane: `` `TYPE_Y ``, `` `TYPE_U ``, `` `TYPE_V ``.
- blk_4x4_x_i  in  4  4x4 column index.
- blk_4x4_y_i  in  4  4x4 row index.
- blk_dat_i  in  16*COEFF_WIDTH  coefficients p0..p15 (p0 in MSBs), in CABAC read order.
- flush_i  in  1  single-cycle pulse at CU end: drain any pending half.
- wr_ena_o  out  1  memory write enable, active-high.
- wr_sel_o  out  2  memory plane code: Y=2, U=1, V=0.
- wr_addr_o  out  7  word address {y[3:1], x[3:0]}.
- wr_msk_o  out  2  half-enable: bit1 = hi half (y[0]=0), bit0 = lo half (y[0]=1).
- wr_dat_o  out  32*COEFF_WIDTH  packed word.
- flush_done_o  out  1  one-cycle pulse when the flush has fully drained.

## Operation

- Un-scramble the input block to raster coefficients c00..c15:
  - c00=p0, c01=p2, c02=p8, c03=p10
  - c04=p1, c05=p3, c06=p9, c07=p11
  - c08=p4, c09=p6, c10=p12, c11=p14
  - c12=p5, c13=p7, c14=p13, c15=p15
- Word layout, MSB first: {H row0, L row0, H row1, L row1, H row2, L row2, H row3, L row3}. Each row is 4 coefficients, c(4r) first. H is the y[0]=0 block, L is the y[0]=1 block.
- Pair key: {sel, x, y[3:1]}. Either half may arrive first.
- State machine:
  - EMPTY: on an accepted block, store it as pending and go to HOLD.
  - HOLD, accepted block with the same key and the opposite half: write the full word (msk=2'b11) and go to EMPTY.
  - HOLD, accepted block with a different key or the same half: write the pending block alone, store the new block as pending, stay in HOLD.
  - HOLD with flush_i and no block: write the pending block alone and go to EMPTY. flush_done_o is asserted with the write.
  - EMPTY with flush_i: flush_done_o is asserted next cycle with no write.
  - flush_i together with an accepted block in HOLD that causes a mismatch: write the old block this cycle and go to DRAIN.
  - DRAIN: write the new block alone, pulse flush_done_o, go to EMPTY.
  - flush_i together with an accepted block in HOLD that completes the pair: full write and flush_done_o in the same registered cycle.
  - flush_i together with an accepted block in EMPTY: store the block, then drain it via DRAIN on the next cycle.
- blk_rdy_o = 0 only in DRAIN. It is 1 otherwise, including during reset release.
- An unknown blk_sel_i value maps to the Y plane code (2).

## Timing

- All outputs are registered. A write appears 1 cycle after the accepting (or flush) edge. At most one write per cycle.
- Reset values: wr_ena_o=0, wr_sel_o=0, wr_addr_o=0, wr_msk_o=0, wr_dat_o=0, flush_done_o=0, state=EMPTY, pending discarded.
- blk_rdy_o is 1 in the first cycle after reset.
- Reset mid-operation drops the pending half with no write.
- wr_dat_o and wr_addr_o are held from the last write while wr_ena_o=0.

## Configuration

- COE_WR_MASK_EN defined: a lone-half write drives wr_msk_o with only that half's bit set (2'b10 or 2'b01). The other half of wr_dat_o holds its last value.
- COE_WR_MASK_EN undefined: every write has wr_msk_o=2'b11, and the missing half is zero-filled.

## Test plan

- Y block (x=3, y=4, p_i=i) then (x=3, y=5, p_i=100+i). Expect one write at addr {3'd2,4'd3}, sel=2, msk=11. Word row0 = 0,2,8,10,100,102,108,110.
- Lo-first pairing: U block (x=0, y=1), then (x=0, y=0). Expect one write, sel=1, addr 0, halves placed correctly.
- Mismatch: V block (x=1, y=0), then (x=2, y=0). Expect a write of addr 1 with msk=10 (zero-filled lo half without the macro), then HOLD on x=2.
- flush_i together with a mismatching block: two consecutive writes, blk_rdy_o=0 for one cycle, flush_done_o on the second write.
- rst asserted while in HOLD, then a flush: no write, flush_done_o one cycle later.
- Round trip: random blocks pass through the packer, then through the CABAC read-side reorder. Read-back equals the input for 256 blocks of each plane.

Source files
------------

// File: rtl/coe_wr_pack.sv
// ---------------------------------------------------------------------------
// coe_wr_pack -- coefficient-buffer write packer for the CABAC coefficient
// memory. Accepts one quantized 4x4 block per handshake and pairs vertically
// adjacent blocks (same x, y differing only in bit 0) into one 32-coefficient
// memory word. Unpaired halves are written alone on a key mismatch or when
// flush_i drains the packer at CU end.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   blk_val_i/rdy_o   input block handshake (rdy low only while draining)
//   blk_sel_i         plane (`TYPE_Y / `TYPE_U / `TYPE_V)
//   blk_4x4_x_i/y_i   4x4 column / row index
//   blk_dat_i         p0..p15, p0 in the MSBs, CABAC read order
//   flush_i           CU-end pulse: drain any pending half
//   wr_ena_o          memory write enable
//   wr_sel_o          plane code Y=2, U=1, V=0
//   wr_addr_o         {y[3:1], x[3:0]}
//   wr_msk_o          bit1 = hi half (y[0]=0), bit0 = lo half (y[0]=1)
//   wr_dat_o          {H row0, L row0, ..., H row3, L row3}
//   flush_done_o      one-cycle pulse when a flush has fully drained
//
// Build option: COE_WR_MASK_EN -- when defined, a lone-half write sets only
// that half's mask bit and leaves the other half of wr_dat_o unchanged; when
// undefined, every write uses mask 2'b11 and the missing half is zero-filled.
// ---------------------------------------------------------------------------
`ifndef COEFF_WIDTH
`define COEFF_WIDTH 16
`endif
`ifndef TYPE_Y
`define TYPE_Y 2'b00
`endif
`ifndef TYPE_U
`define TYPE_U 2'b10
`endif
`ifndef TYPE_V
`define TYPE_V 2'b11
`endif

module coe_wr_pack (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        blk_val_i,
  output logic                        blk_rdy_o,
  input  logic [1:0]                  blk_sel_i,
  input  logic [3:0]                  blk_4x4_x_i,
  input  logic [3:0]                  blk_4x4_y_i,
  input  logic [16*`COEFF_WIDTH-1:0]  blk_dat_i,
  input  logic                        flush_i,
  output logic                        wr_ena_o,
  output logic [1:0]                  wr_sel_o,
  output logic [6:0]                  wr_addr_o,
  output logic [1:0]                  wr_msk_o,
  output logic [32*`COEFF_WIDTH-1:0]  wr_dat_o,
  output logic                        flush_done_o
);

  localparam int W = `COEFF_WIDTH;

  typedef enum logic [1:0] {S_EMPTY, S_HOLD, S_DRAIN} state_t;

  // Per-half data source for the outgoing word.
  localparam logic [1:0] SRC_ZERO = 2'd0;
  localparam logic [1:0] SRC_PEND = 2'd1;
  localparam logic [1:0] SRC_NEW  = 2'd2;
  localparam logic [1:0] SRC_OLD  = 2'd3;

  state_t         state_q, state_d;
  logic [W-1:0]   new_c  [16];   // incoming block, raster order
  logic [W-1:0]   pend_q [16];   // pending half, raster order
  logic [W-1:0]   old_h  [16];   // hi half currently on wr_dat_o
  logic [W-1:0]   old_l  [16];   // lo half currently on wr_dat_o
  logic [W-1:0]   h_c    [16];
  logic [W-1:0]   l_c    [16];
  logic [8:0]     pend_key_q;    // {plane code, y[3:1], x}
  logic           pend_half_q;   // y[0] of the pending block
  logic [1:0]     new_code;
  logic [8:0]     new_key;
  logic           accept, pair_hit, store;
  logic           lone;
  logic [1:0]     h_src, l_src;

  logic                 wr_ena_q, wr_ena_d;
  logic [8:0]           wr_key_q, wr_key_d;
  logic [1:0]           wr_msk_q, wr_msk_d;
  logic [32*W-1:0]      wr_dat_q, wr_dat_d;
  logic                 flush_done_q, flush_done_d;
  logic                 rdy_q;

  always_comb begin
    case (blk_sel_i)
      `TYPE_U: new_code = 2'd1;
      `TYPE_V: new_code = 2'd0;
      default: new_code = 2'd2;   // Y and any unknown code
    endcase
  end

  assign new_key  = {new_code, blk_4x4_y_i[3:1], blk_4x4_x_i};
  assign accept   = blk_val_i & rdy_q;
  assign pair_hit = (new_key == pend_key_q) && (blk_4x4_y_i[0] != pend_half_q);
  assign store    = accept && !((state_q == S_HOLD) && pair_hit);

  // Raster coefficient c(4r+k) comes from p[(r&1) + 4(r>>1) + 2(k&1) + 8(k>>1)];
  // in the word, H row r sits at slot 8r+k and L row r at slot 8r+4+k (slot 0 = MSB).
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_coef
      localparam int PI = ((gi / 4) % 2) + (gi / 8) * 4 + (gi % 2) * 2 + ((gi % 4) / 2) * 8;
      localparam int HS = 8 * (gi / 4) + (gi % 4);
      localparam int LS = HS + 4;

      assign new_c[gi] = blk_dat_i[(15 - PI)*W +: W];
      assign old_h[gi] = wr_dat_q[(31 - HS)*W +: W];
      assign old_l[gi] = wr_dat_q[(31 - LS)*W +: W];

      assign h_c[gi] = (h_src == SRC_PEND) ? pend_q[gi] :
                       (h_src == SRC_NEW)  ? new_c[gi]  :
                       (h_src == SRC_OLD)  ? old_h[gi]  : '0;
      assign l_c[gi] = (l_src == SRC_PEND) ? pend_q[gi] :
                       (l_src == SRC_NEW)  ? new_c[gi]  :
                       (l_src == SRC_OLD)  ? old_l[gi]  : '0;

      assign wr_dat_d[(31 - HS)*W +: W] = h_c[gi];
      assign wr_dat_d[(31 - LS)*W +: W] = l_c[gi];
    end
  endgenerate

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_EMPTY;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (accept) state_d = flush_i ? S_DRAIN : S_HOLD;
      S_HOLD: begin
        if (accept) begin
          if (pair_hit)     state_d = S_EMPTY;
          else if (flush_i) state_d = S_DRAIN;
          else              state_d = S_HOLD;
        end else if (flush_i) begin
          state_d = S_EMPTY;
        end
      end
      S_DRAIN: state_d = S_EMPTY;
      default: state_d = S_EMPTY;
    endcase
  end

  // Output logic: what the next registered write looks like
  always_comb begin
    wr_ena_d     = 1'b0;
    wr_key_d     = pend_key_q;    // a full pair shares the pending key
    wr_msk_d     = 2'b11;
    flush_done_d = 1'b0;
    h_src        = SRC_ZERO;
    l_src        = SRC_ZERO;
    lone         = 1'b0;
    case (state_q)
      S_EMPTY: if (flush_i && !accept) flush_done_d = 1'b1;
      S_HOLD: begin
        if (accept) begin
          wr_ena_d = 1'b1;
          if (pair_hit) begin
            flush_done_d = flush_i;
            h_src = pend_half_q ? SRC_NEW  : SRC_PEND;
            l_src = pend_half_q ? SRC_PEND : SRC_NEW;
          end else begin
            lone = 1'b1;
          end
        end else if (flush_i) begin
          wr_ena_d     = 1'b1;
          flush_done_d = 1'b1;
          lone         = 1'b1;
        end
      end
      S_DRAIN: begin
        wr_ena_d     = 1'b1;
        flush_done_d = 1'b1;
        lone         = 1'b1;
      end
      default: ;
    endcase
    if (lone) begin
`ifdef COE_WR_MASK_EN
      wr_msk_d = pend_half_q ? 2'b01 : 2'b10;
      h_src    = pend_half_q ? SRC_OLD  : SRC_PEND;
      l_src    = pend_half_q ? SRC_PEND : SRC_OLD;
`else
      wr_msk_d = 2'b11;
      h_src    = pend_half_q ? SRC_ZERO : SRC_PEND;
      l_src    = pend_half_q ? SRC_PEND : SRC_ZERO;
`endif
    end
  end

  // Registered outputs; address/data hold their last written value.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ena_q     <= 1'b0;
      wr_key_q     <= '0;
      wr_msk_q     <= '0;
      wr_dat_q     <= '0;
      flush_done_q <= 1'b0;
      rdy_q        <= 1'b1;
      pend_key_q   <= '0;
      pend_half_q  <= 1'b0;
    end else begin
      wr_ena_q     <= wr_ena_d;
      flush_done_q <= flush_done_d;
      rdy_q        <= (state_d != S_DRAIN);
      if (wr_ena_d) begin
        wr_key_q <= wr_key_d;
        wr_msk_q <= wr_msk_d;
        wr_dat_q <= wr_dat_d;
      end
      if (store) begin
        pend_key_q  <= new_key;
        pend_half_q <= blk_4x4_y_i[0];
      end
    end
  end

  // Pending coefficients need no reset: state EMPTY marks them invalid.
  always_ff @(posedge clk) begin
    if (store) pend_q <= new_c;
  end

  assign blk_rdy_o    = rdy_q;
  assign wr_ena_o     = wr_ena_q;
  assign wr_sel_o     = wr_key_q[8:7];
  assign wr_addr_o    = wr_key_q[6:0];
  assign wr_msk_o     = wr_msk_q;
  assign wr_dat_o     = wr_dat_q;
  assign flush_done_o = flush_done_q;

endmodule

// File: tb/tb_coe_wr_pack.sv
`ifndef COEFF_WIDTH
`define COEFF_WIDTH 16
`endif
`ifndef TYPE_Y
`define TYPE_Y 2'b00
`endif
`ifndef TYPE_U
`define TYPE_U 2'b10
`endif
`ifndef TYPE_V
`define TYPE_V 2'b11
`endif

module tb_coe_wr_pack;
  localparam int W = `COEFF_WIDTH;
`ifdef COE_WR_MASK_EN
  localparam bit MASK = 1'b1;
`else
  localparam bit MASK = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              blk_val_i;
  logic              blk_rdy_o;
  logic [1:0]        blk_sel_i;
  logic [3:0]        blk_4x4_x_i;
  logic [3:0]        blk_4x4_y_i;
  logic [16*W-1:0]   blk_dat_i;
  logic              flush_i;
  logic              wr_ena_o;
  logic [1:0]        wr_sel_o;
  logic [6:0]        wr_addr_o;
  logic [1:0]        wr_msk_o;
  logic [32*W-1:0]   wr_dat_o;
  logic              flush_done_o;

  coe_wr_pack dut (
    .clk          (clk),
    .rst          (rst),
    .blk_val_i    (blk_val_i),
    .blk_rdy_o    (blk_rdy_o),
    .blk_sel_i    (blk_sel_i),
    .blk_4x4_x_i  (blk_4x4_x_i),
    .blk_4x4_y_i  (blk_4x4_y_i),
    .blk_dat_i    (blk_dat_i),
    .flush_i      (flush_i),
    .wr_ena_o     (wr_ena_o),
    .wr_sel_o     (wr_sel_o),
    .wr_addr_o    (wr_addr_o),
    .wr_msk_o     (wr_msk_o),
    .wr_dat_o     (wr_dat_o),
    .flush_done_o (flush_done_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Raster index j -> p index, straight from the un-scramble table.
  int uns [16] = '{0, 2, 8, 10, 1, 3, 9, 11, 4, 6, 12, 14, 5, 7, 13, 15};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_blk(input string nm, input logic [16*W-1:0] act, input logic [16*W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [16*W-1:0] make_blk(input int base);
    logic [16*W-1:0] b;
    for (int i = 0; i < 16; i++) b[(15-i)*W +: W] = W'(base + i);
    return b;
  endfunction

  // CABAC read side: pull one half out of the word and re-scramble to p order.
  function automatic logic [16*W-1:0] readback(input logic [32*W-1:0] word, input bit lo);
    logic [16*W-1:0] b;
    int slot;
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++) begin
        slot = 8*r + (lo ? 4 : 0) + k;
        b[(15-uns[4*r+k])*W +: W] = word[(31-slot)*W +: W];
      end
    return b;
  endfunction

  typedef struct {
    bit       val;
    logic [1:0] sel;
    int       x, y, base;
    bit       flush;
    bit       e_ena;
    int       e_sel, e_addr;
    bit       e_done, e_rdy;
    int       h_base, l_base;   // -1: half not written by this write
  } vec_t;

  function automatic vec_t mk(input bit val, input logic [1:0] sel, input int x, input int y,
                              input int base, input bit flush, input bit e_ena, input int e_sel,
                              input int e_addr, input bit e_done, input bit e_rdy,
                              input int h_base, input int l_base);
    vec_t v;
    v.val = val; v.sel = sel; v.x = x; v.y = y; v.base = base; v.flush = flush;
    v.e_ena = e_ena; v.e_sel = e_sel; v.e_addr = e_addr; v.e_done = e_done;
    v.e_rdy = e_rdy; v.h_base = h_base; v.l_base = l_base;
    return v;
  endfunction

  localparam int NV = 23;
  vec_t vecs [NV];

  task automatic idle_inputs();
    blk_val_i = 1'b0; blk_sel_i = 2'b00; blk_4x4_x_i = '0; blk_4x4_y_i = '0;
    blk_dat_i = '0; flush_i = 1'b0;
  endtask

  initial begin
    logic [1:0]      exp_msk;
    logic [16*W-1:0] blk_a, blk_b, blk_h, blk_l;
    int              row0 [8];
    logic [1:0]      psel [3];
    int              pcode [3];
    int              rx, ryh;
    bit              first_lo;

    row0 = '{0, 2, 8, 10, 100, 102, 108, 110};
    psel = '{`TYPE_Y, `TYPE_U, `TYPE_V};
    pcode = '{2, 1, 0};

    //            val sel      x  y  base  fl ena sel addr done rdy  H     L
    vecs[0]  = mk(1, `TYPE_Y, 3, 4, 0,    0, 0, 0, 0,  0, 1, -1,   -1);
    vecs[1]  = mk(1, `TYPE_Y, 3, 5, 100,  0, 1, 2, 35, 0, 1, 0,    100);
    vecs[2]  = mk(1, `TYPE_U, 0, 1, 200,  0, 0, 0, 0,  0, 1, -1,   -1);
    vecs[3]  = mk(1, `TYPE_U, 0, 0, 300,  0, 1, 1, 0,  0, 1, 300,  200);
    vecs[4]  = mk(1, `TYPE_V, 1, 0, 400,  0, 0, 0, 0,  0, 1, -1,   -1);
    vecs[5]  = mk(1, `TYPE_V, 2, 0, 500,  0, 1, 0, 1,  0, 1, 400,  -1);
    vecs[6]  = mk(0, `TYPE_Y, 0, 0, 0,    1, 1, 0, 2,  1, 1, 500,  -1);
    vecs[7]  = mk(0, `TYPE_Y, 0, 0, 0,    1, 0, 0, 0,  1, 1, -1,   -1);
    vecs[8]  = mk(0, `TYPE_Y, 0, 0, 0,    0, 0, 0, 0,  0, 1, -1,   -1);
    vecs[9]  = mk(1, `TYPE_Y, 5, 3, 600,  0, 0, 0, 0,  0, 1, -1,   -1);
    vecs[10] = mk(1, `TYPE_Y, 5, 4, 700,  1, 1, 2, 21, 0, 0, -1,   600);
    vecs[11] = mk(1, `TYPE_Y, 5, 5, 800,  0, 1, 2, 37, 1, 1, 700,  -1);
    vecs[12] = mk(0, `TYPE_Y, 0, 0, 0,    1, 0, 0, 0,  1, 1, -1,   -1);
    vecs[13] = mk(1, `TYPE_Y, 6, 0, 900,  0, 0, 0, 0,  0, 1, -1,   -1);
    vecs[14] = mk(1, `TYPE_Y, 6, 0, 1000, 0, 1, 2, 6,  0, 1, 900,  -1);
    vecs[15] = mk(1, `TYPE_U, 6, 1, 1100, 0, 1, 2, 6,  0, 1, 1000, -1);
    vecs[16] = mk(1, `TYPE_U, 6, 0, 1200, 0, 1, 1, 6,  0, 1, 1200, 1100);
    vecs[17] = mk(1, `TYPE_V, 7, 8, 1300, 0, 0, 0, 0,  0, 1, -1,   -1);
    vecs[18] = mk(1, `TYPE_V, 7, 9, 1400, 1, 1, 0, 71, 1, 1, 1300, 1400);
    vecs[19] = mk(1, `TYPE_Y, 0, 0, 1500, 1, 0, 0, 0,  0, 0, -1,   -1);
    vecs[20] = mk(0, `TYPE_Y, 0, 0, 0,    0, 1, 2, 0,  1, 1, 1500, -1);
    vecs[21] = mk(1, 2'b01,   1, 2, 1600, 0, 0, 0, 0,  0, 1, -1,   -1);
    vecs[22] = mk(0, `TYPE_Y, 0, 0, 0,    1, 1, 2, 17, 1, 1, 1600, -1);

    // Reset state
    rst = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ena",  64'(wr_ena_o), 64'd0);
    chk("rst_sel",  64'(wr_sel_o), 64'd0);
    chk("rst_addr", 64'(wr_addr_o), 64'd0);
    chk("rst_msk",  64'(wr_msk_o), 64'd0);
    chk("rst_done", 64'(flush_done_o), 64'd0);
    chk("rst_dat",  64'(wr_dat_o == '0), 64'd1);
    chk("rst_rdy",  64'(blk_rdy_o), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rel_rdy", 64'(blk_rdy_o), 64'd1);

    // Directed vector table
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      blk_val_i   = vecs[i].val;
      blk_sel_i   = vecs[i].sel;
      blk_4x4_x_i = 4'(vecs[i].x);
      blk_4x4_y_i = 4'(vecs[i].y);
      blk_dat_i   = make_blk(vecs[i].base);
      flush_i     = vecs[i].flush;
      @(posedge clk); #1;
      $display("vec %0d: ena=%0d sel=%0d addr=%0d msk=%b done=%0d rdy=%0d",
               i, wr_ena_o, wr_sel_o, wr_addr_o, wr_msk_o, flush_done_o, blk_rdy_o);
      chk($sformatf("v%0d_ena", i),  64'(wr_ena_o), 64'(vecs[i].e_ena));
      chk($sformatf("v%0d_done", i), 64'(flush_done_o), 64'(vecs[i].e_done));
      chk($sformatf("v%0d_rdy", i),  64'(blk_rdy_o), 64'(vecs[i].e_rdy));
      if (vecs[i].e_ena) begin
        if (vecs[i].h_base >= 0 && vecs[i].l_base >= 0) exp_msk = 2'b11;
        else if (!MASK)                                  exp_msk = 2'b11;
        else if (vecs[i].h_base >= 0)                    exp_msk = 2'b10;
        else                                             exp_msk = 2'b01;
        chk($sformatf("v%0d_sel", i),  64'(wr_sel_o), 64'(vecs[i].e_sel));
        chk($sformatf("v%0d_addr", i), 64'(wr_addr_o), 64'(vecs[i].e_addr));
        chk($sformatf("v%0d_msk", i),  64'(wr_msk_o), 64'(exp_msk));
        if (vecs[i].h_base >= 0)
          chk_blk($sformatf("v%0d_hi", i), readback(wr_dat_o, 1'b0), make_blk(vecs[i].h_base));
        else if (!MASK)
          chk_blk($sformatf("v%0d_hi0", i), readback(wr_dat_o, 1'b0), '0);
        if (vecs[i].l_base >= 0)
          chk_blk($sformatf("v%0d_lo", i), readback(wr_dat_o, 1'b1), make_blk(vecs[i].l_base));
        else if (!MASK)
          chk_blk($sformatf("v%0d_lo0", i), readback(wr_dat_o, 1'b1), '0);
      end
      if (i == 1)
        for (int s = 0; s < 8; s++)
          chk($sformatf("row0_slot%0d", s), 64'(wr_dat_o[(31-s)*W +: W]), 64'(row0[s]));
    end
    @(negedge clk);
    idle_inputs();
    @(posedge clk); #1;
    chk("idle_ena", 64'(wr_ena_o), 64'd0);

    // Reset while holding a half, then flush: nothing written, done next cycle
    @(negedge clk);
    blk_val_i = 1'b1; blk_sel_i = `TYPE_Y; blk_4x4_x_i = 4'd2; blk_4x4_y_i = 4'd2;
    blk_dat_i = make_blk(2000);
    @(posedge clk); #1;
    chk("mr_hold_ena", 64'(wr_ena_o), 64'd0);
    @(negedge clk);
    idle_inputs(); rst = 1'b1;
    @(posedge clk); #1;
    chk("mr_rst_ena", 64'(wr_ena_o), 64'd0);
    chk("mr_rst_rdy", 64'(blk_rdy_o), 64'd1);
    @(negedge clk);
    rst = 1'b0; flush_i = 1'b1;
    @(posedge clk); #1;
    $display("midreset flush: ena=%0d done=%0d", wr_ena_o, flush_done_o);
    chk("mr_fl_ena",  64'(wr_ena_o), 64'd0);
    chk("mr_fl_done", 64'(flush_done_o), 64'd1);
    @(negedge clk);
    flush_i = 1'b0;
    @(posedge clk); #1;
    chk("mr_after_ena",  64'(wr_ena_o), 64'd0);
    chk("mr_after_done", 64'(flush_done_o), 64'd0);

    // Round trip: 256 random blocks per plane, paired in random order
    for (int p = 0; p < 3; p++) begin
      for (int n = 0; n < 128; n++) begin
        rx       = int'($urandom_range(0, 15));
        ryh      = int'($urandom_range(0, 7));
        first_lo = 1'($urandom_range(0, 1));
        for (int c = 0; c < 16; c++) begin
          blk_a[c*W +: W] = W'($urandom);
          blk_b[c*W +: W] = W'($urandom);
        end
        @(negedge clk);
        blk_val_i = 1'b1; blk_sel_i = psel[p]; blk_4x4_x_i = 4'(rx);
        blk_4x4_y_i = {3'(ryh), first_lo}; blk_dat_i = blk_a;
        @(posedge clk); #1;
        chk($sformatf("rt%0d_%0d_first", p, n), 64'(wr_ena_o), 64'd0);
        @(negedge clk);
        blk_4x4_y_i = {3'(ryh), ~first_lo}; blk_dat_i = blk_b;
        @(posedge clk); #1;
        blk_h = first_lo ? blk_b : blk_a;
        blk_l = first_lo ? blk_a : blk_b;
        $display("rt plane %0d pair %0d: ena=%0d sel=%0d addr=%0d msk=%b",
                 p, n, wr_ena_o, wr_sel_o, wr_addr_o, wr_msk_o);
        chk($sformatf("rt%0d_%0d_ena", p, n),  64'(wr_ena_o), 64'd1);
        chk($sformatf("rt%0d_%0d_sel", p, n),  64'(wr_sel_o), 64'(pcode[p]));
        chk($sformatf("rt%0d_%0d_addr", p, n), 64'(wr_addr_o), 64'(ryh * 16 + rx));
        chk($sformatf("rt%0d_%0d_msk", p, n),  64'(wr_msk_o), 64'd3);
        chk_blk($sformatf("rt%0d_%0d_hi", p, n), readback(wr_dat_o, 1'b0), blk_h);
        chk_blk($sformatf("rt%0d_%0d_lo", p, n), readback(wr_dat_o, 1'b1), blk_l);
      end
    end
    @(negedge clk);
    idle_inputs();
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
